// File: rtl/seq_slice_adder.sv
// Multi-cycle ripple-carry adder: WIDTH-bit operands summed SLICE bits per clock.
// Optional feature macro SEQ_SLICE_ADDER_SUB_EN adds a `sub` port computing a - b - borrow.
module seq_slice_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef SEQ_SLICE_ADDER_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned NSL      = WIDTH / SLICE;
    localparam int unsigned CW       = (NSL > 1) ? $clog2(NSL) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NSL - 1);

    // Reject geometries that do not split into whole slices.
    if (WIDTH < 1 || SLICE < 1 || SLICE > WIDTH || (WIDTH % SLICE) != 0) begin : g_cfg_check
        $error("seq_slice_adder: WIDTH must be a non-zero multiple of SLICE");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           next_state;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] psum_q;
    logic [WIDTH-1:0] psum_d;
    logic             carry_q;
    logic [CW-1:0]    idx_q;

    logic             accept;
    logic             step;
    logic             last_step;
    logic             busy_d;
    logic             done_d;

    logic [WIDTH-1:0] b_in;
    logic             cin_in;

    logic [SLICE-1:0] a_sl;
    logic [SLICE-1:0] b_sl;
    logic [SLICE-1:0] s_sl;
    logic             c_sl;

    // Subtraction reuses the adder: a + ~b + ~borrow.
`ifdef SEQ_SLICE_ADDER_SUB_EN
    assign b_in   = sub ? ~b : b;
    assign cin_in = sub ? ~cin : cin;
`else
    assign b_in   = b;
    assign cin_in = cin;
`endif

    // Select the active slice and merge its result into the partial sum.
    always_comb begin
        a_sl   = '0;
        b_sl   = '0;
        psum_d = psum_q;
        for (int k = 0; k < int'(NSL); k++) begin
            if (idx_q == CW'(k)) begin
                a_sl                      = a_q[k*SLICE +: SLICE];
                b_sl                      = b_q[k*SLICE +: SLICE];
                psum_d[k*SLICE +: SLICE]  = s_sl;
            end
        end
    end

    // SLICE-bit ripple chain seeded by the inter-slice carry register.
    always_comb begin
        s_sl = '0;
        c_sl = carry_q;
        for (int i = 0; i < int'(SLICE); i++) begin
            s_sl[i] = a_sl[i] ^ b_sl[i] ^ c_sl;
            c_sl    = (a_sl[i] & b_sl[i]) | (c_sl & (a_sl[i] ^ b_sl[i]));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= next_state;
        end
    end

    always_comb begin
        next_state = state_q;
        case (state_q)
            S_IDLE:  if (start) next_state = S_RUN;
            S_RUN:   if (idx_q == LAST_IDX) next_state = S_DONE;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        accept    = 1'b0;
        step      = 1'b0;
        last_step = 1'b0;
        case (state_q)
            S_IDLE: accept = start;
            S_RUN: begin
                step      = 1'b1;
                last_step = (idx_q == LAST_IDX);
            end
            default: ;
        endcase
        busy_d = (next_state != S_IDLE);
        done_d = (next_state == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= busy_d;
            done <= done_d;
        end
    end

    // Operand capture, per-slice accumulation, and result load on the final slice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            psum_q  <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            if (accept) begin
                a_q     <= a;
                b_q     <= b_in;
                carry_q <= cin_in;
                psum_q  <= '0;
                idx_q   <= '0;
            end else if (step) begin
                psum_q  <= psum_d;
                carry_q <= c_sl;
                idx_q   <= last_step ? '0 : idx_q + CW'(1);
            end
            if (last_step) begin
                sum  <= psum_d;
                cout <= c_sl;
            end
        end
    end

endmodule

// File: tb/tb_seq_slice_adder.sv
// Directed and random checks of seq_slice_adder at SLICE=4, 1 and 16 (WIDTH=16), run side by side.
`timescale 1ns/1ps
module tb_seq_slice_adder;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        sub;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;

    logic [2:0]  busy_v;
    logic [2:0]  done_v;
    logic [2:0]  cout_v;
    logic [15:0] sum_v [3];

    int          n_tests;
    int          n_fail;
    int          nsl [3];
    logic [15:0] last_es;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] sum;
        logic        cout;
    } vec_t;

    vec_t vecs[$];

    seq_slice_adder #(.WIDTH(16), .SLICE(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start),
`ifdef SEQ_SLICE_ADDER_SUB_EN
        .sub(sub),
`endif
        .a(a), .b(b), .cin(cin),
        .busy(busy_v[0]), .done(done_v[0]), .sum(sum_v[0]), .cout(cout_v[0])
    );

    seq_slice_adder #(.WIDTH(16), .SLICE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start),
`ifdef SEQ_SLICE_ADDER_SUB_EN
        .sub(sub),
`endif
        .a(a), .b(b), .cin(cin),
        .busy(busy_v[1]), .done(done_v[1]), .sum(sum_v[1]), .cout(cout_v[1])
    );

    seq_slice_adder #(.WIDTH(16), .SLICE(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start(start),
`ifdef SEQ_SLICE_ADDER_SUB_EN
        .sub(sub),
`endif
        .a(a), .b(b), .cin(cin),
        .busy(busy_v[2]), .done(done_v[2]), .sum(sum_v[2]), .cout(cout_v[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One start pulse to all three instances; checks result, latency, single pulse, busy release.
    task automatic run_op(input string tag, input logic [15:0] va, input logic [15:0] vb,
                          input logic vc, input logic vs, input logic [15:0] es, input logic ec);
        int first [3];
        int ndone [3];
        for (int i = 0; i < 3; i++) begin
            first[i] = 0;
            ndone[i] = 0;
        end
        a = va; b = vb; cin = vc; sub = vs; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (done_v[i]) begin
                    ndone[i]++;
                    if (first[i] == 0) begin
                        first[i] = k;
                        check($sformatf("%s d%0d sum", tag, i), 32'(sum_v[i]), 32'(es));
                        check($sformatf("%s d%0d cout", tag, i), 32'(cout_v[i]), 32'(ec));
                    end
                end
                if (k == nsl[i] + 1)
                    check($sformatf("%s d%0d busy/done after", tag, i),
                          32'({busy_v[i], done_v[i]}), 32'(0));
            end
        end
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s d%0d latency", tag, i), 32'(first[i]), 32'(nsl[i]));
            check($sformatf("%s d%0d done count", tag, i), 32'(ndone[i]), 32'(1));
        end
        last_es = es;
    endtask

    initial begin
        int          got;
        int          ndone;
        logic [16:0] full;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;

        n_tests = 0;
        n_fail  = 0;
        nsl[0]  = 4;
        nsl[1]  = 16;
        nsl[2]  = 1;
        last_es = '0;
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;

        vecs.push_back('{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0});
        vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1});
        vecs.push_back('{16'h6666, 16'hCCCC, 1'b1, 1'b0, 16'h3333, 1'b1});
        vecs.push_back('{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0});
        vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1});
        vecs.push_back('{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1});
        vecs.push_back('{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0});
        vecs.push_back('{16'h0F0F, 16'hF0F0, 1'b1, 1'b0, 16'h0000, 1'b1});
        vecs.push_back('{16'hABCD, 16'h1111, 1'b0, 1'b0, 16'hBCDE, 1'b0});
        vecs.push_back('{16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0});
`ifdef SEQ_SLICE_ADDER_SUB_EN
        vecs.push_back('{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0});
        vecs.push_back('{16'h0009, 16'h0003, 1'b1, 1'b1, 16'h0005, 1'b1});
        vecs.push_back('{16'h0009, 16'h0003, 1'b1, 1'b0, 16'h000D, 1'b0});
`endif

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("reset busy", 32'(busy_v[0]), 32'(0));
        check("reset done", 32'(done_v[0]), 32'(0));
        check("reset sum", 32'(sum_v[0]), 32'(0));
        check("reset cout", 32'(cout_v[0]), 32'(0));
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < vecs.size(); v++)
            run_op($sformatf("vec%0d", v), vecs[v].a, vecs[v].b, vecs[v].cin, vecs[v].sub,
                   vecs[v].sum, vecs[v].cout);

        for (int r = 0; r < 1000; r++) begin
            ra   = 16'($urandom_range(0, 65535));
            rb   = 16'($urandom_range(0, 65535));
            rc   = 1'($urandom_range(0, 1));
            full = 17'(ra) + 17'(rb) + 17'(rc);
            run_op($sformatf("rnd%0d a=%h b=%h c=%b", r, ra, rb, rc), ra, rb, rc, 1'b0,
                   full[15:0], full[16]);
        end

        // start held high through RUN with changing operands: one done, original operands
        a = 16'h1234; b = 16'h1111; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        check("hold busy", 32'(busy_v[0]), 32'(1));
        a = 16'hFFFF;
        got = 0;
        for (int k = 1; k <= 10 && got == 0; k++) begin
            @(negedge clk);
            if (done_v[0]) begin
                got = k;
                check("hold sum", 32'(sum_v[0]), 32'(16'h2345));
                check("hold cout", 32'(cout_v[0]), 32'(0));
            end else begin
                check($sformatf("hold sum stable k%0d", k), 32'(sum_v[0]), 32'(last_es));
            end
        end
        check("hold latency", 32'(got), 32'(4));
        a = 16'h0001; b = 16'h0002;
        @(negedge clk);
        check("hold single done", 32'({busy_v[0], done_v[0]}), 32'(0));
        @(negedge clk);
        check("restart accepted", 32'(busy_v[0]), 32'(1));
        start = 1'b0;
        got = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (done_v[0] && got == 0) begin
                got = k;
                check("restart sum", 32'(sum_v[0]), 32'(16'h0003));
            end
        end
        check("restart latency", 32'(got), 32'(4));

        // Async reset in the middle of RUN (slice index 2 for SLICE=4)
        a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrun reset busy", 32'(busy_v[0]), 32'(0));
        check("midrun reset done", 32'(done_v[0]), 32'(0));
        check("midrun reset sum", 32'(sum_v[0]), 32'(0));
        check("midrun reset cout", 32'(cout_v[0]), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done_v != 3'b000) ndone++;
        end
        check("midrun reset no done", 32'(ndone), 32'(0));
        run_op("post reset", 16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
